// File: rtl/router_pkt_reader.sv
// Drain engine for one router output FIFO: issues reads, hides the 1-cycle read
// latency in a 2-entry skid buffer, frames packets and reports parity/stall events.
module router_pkt_reader #(
  parameter int TIMEOUT_CYCLES = 30,
  parameter int CNT_W          = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       soft_reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_enb,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_sop,
  output logic       m_eop,
  output logic       busy,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, HDR_WAIT, BODY, DRAIN} state_e;

  typedef struct packed {
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } entry_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  entry_t           head_q, head_d, tail_q, tail_d, landEntry;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [6:0]       reqRem_q, reqRem_d, landRem_q, landRem_d;
  logic [7:0]       xorAcc_q, xorAcc_d;
  logic             perr_q, perr_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic             timeout_q, timeout_d;
  logic             flush, pop, reqOk, rdEn, lastLand, eopPop;
  logic [2:0]       fill;

  assign flush    = !resetn || soft_reset;
  assign pop      = (occ_q != 2'd0) && m_ready;
  assign fill     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign reqOk    = (state_q == IDLE) || ((state_q == BODY) && (reqRem_q != 7'd0));
  assign rdEn     = !flush && !fifo_empty && reqOk && (fill < 3'd2);
  assign lastLand = (state_q == BODY) && inflight_q && (landRem_q == 7'd1);
  assign eopPop   = (state_q == DRAIN) && pop && head_q.eop;

  // Framing FSM: counts reads and landings separately because a read lands one cycle late.
  always_comb begin
    state_d   = state_q;
    reqRem_d  = reqRem_q;
    landRem_d = landRem_q;
    xorAcc_d  = xorAcc_q;
    perr_d    = perr_q;
    case (state_q)
      IDLE: begin
        if (rdEn) state_d = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (inflight_q) begin
          reqRem_d  = {1'b0, fifo_data[7:2]} + 7'd1;
          landRem_d = {1'b0, fifo_data[7:2]} + 7'd1;
          xorAcc_d  = fifo_data;
          state_d   = BODY;
        end
      end
      BODY: begin
        if (rdEn) reqRem_d = reqRem_q - 7'd1;
        if (inflight_q) begin
          xorAcc_d  = xorAcc_q ^ fifo_data;
          landRem_d = landRem_q - 7'd1;
          if (landRem_q == 7'd1) begin
            perr_d  = (xorAcc_q ^ fifo_data) != 8'h00;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (eopPop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: vacated slots are zeroed so the head reads 0 whenever the buffer is empty.
  always_comb begin
    landEntry.data = fifo_data;
    landEntry.sop  = (state_q == HDR_WAIT);
    landEntry.eop  = lastLand;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = tail_q;
      tail_d = '0;
    end
    if (inflight_q) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) head_d = landEntry;
      else                                             tail_d = landEntry;
    end
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (!m_valid || pop)        stallCnt_d = '0;
    else if (stallCnt_q != TMO) stallCnt_d = stallCnt_q + CNT_W'(1);
    timeout_d = (stallCnt_d == TMO) && (stallCnt_q != TMO);
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      reqRem_q   <= 7'd0;
      landRem_q  <= 7'd0;
      xorAcc_q   <= 8'h00;
      perr_q     <= 1'b0;
      stallCnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= rdEn;
      reqRem_q   <= reqRem_d;
      landRem_q  <= landRem_d;
      xorAcc_q   <= xorAcc_d;
      perr_q     <= perr_d;
      stallCnt_q <= stallCnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign fifo_read_enb = rdEn;
  assign m_data        = head_q.data;
  assign m_valid       = (occ_q != 2'd0);
  assign m_sop         = head_q.sop;
  assign m_eop         = head_q.eop;
  assign busy          = (state_q != IDLE);
  assign pkt_done      = eopPop && !flush;
  assign parity_err    = eopPop && !flush && perr_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader: a pointer-based FIFO model feeds the DUT and
// each scenario task checks the stream, framing flags and status pulses it expects.
module tb_router_pkt_reader;

  logic       clock = 1'b0;
  logic       resetn, soft_reset, m_ready;
  logic       fifo_empty, fifo_read_enb;
  logic [7:0] fifo_data = 8'h00;
  logic [7:0] m_data;
  logic       m_valid, m_sop, m_eop, busy, pkt_done, parity_err, timeout;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];
  int wrPtr = 0;
  int rdPtr = 0;

  logic [9:0] rxQ[$];
  int  tbOcc, tbInflight, maxOcc, rdViol, validViol;
  int  doneCnt, errCnt, strayDone, timeoutCnt;

  always #5 clock = ~clock;

  router_pkt_reader #(.TIMEOUT_CYCLES(30), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_enb(fifo_read_enb),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sop(m_sop), .m_eop(m_eop), .busy(busy),
    .pkt_done(pkt_done), .parity_err(parity_err), .timeout(timeout)
  );

  // Registered-read FIFO model; a reset or soft reset flushes it like the router does.
  assign fifo_empty = (rdPtr == wrPtr);
  always @(posedge clock) begin
    if (!resetn || soft_reset) rdPtr <= wrPtr;
    else if (fifo_read_enb) begin
      fifo_data <= mem[rdPtr];
      rdPtr     <= rdPtr + 1;
    end
  end

  task automatic pushByte(input logic [7:0] b);
    mem[wrPtr] = b;
    wrPtr = wrPtr + 1;
  endtask

  task automatic clearRx();
    rxQ.delete();
    tbOcc = 0; tbInflight = 0; maxOcc = 0; rdViol = 0; validViol = 0;
    doneCnt = 0; errCnt = 0; strayDone = 0; timeoutCnt = 0;
  endtask

  // Streams cycles until pkt_done or the budget runs out, tracking occupancy from the ports.
  task automatic runStream(input int maxCyc, input bit toggleReady, output bit finished);
    bit pop;
    finished = 1'b0;
    for (int c = 0; c < maxCyc && !finished; c++) begin
      if (toggleReady) m_ready = ((c % 2) == 0);
      #1;
      pop = m_valid && m_ready;
      if (fifo_read_enb && (tbOcc + tbInflight - int'(pop)) >= 2) rdViol++;
      if (m_valid !== (tbOcc != 0)) validViol++;
      if (pop) rxQ.push_back({m_sop, m_eop, m_data});
      if (timeout) timeoutCnt++;
      if (pkt_done) begin
        doneCnt++;
        if (!(pop && m_eop)) strayDone++;
        if (parity_err) errCnt++;
        finished = 1'b1;
      end
      if (parity_err && !pkt_done) strayDone++;
      tbOcc      = tbOcc + tbInflight - int'(pop);
      tbInflight = int'(fifo_read_enb);
      if (tbOcc > maxOcc) maxOcc = tbOcc;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; soft_reset = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({m_valid, m_sop, m_eop, busy, pkt_done, parity_err, timeout, fifo_read_enb} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 00000000",
               {m_valid, m_sop, m_eop, busy, pkt_done, parity_err, timeout, fifo_read_enb});
    end
    checks++;
    if (m_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", m_data); end
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({m_valid, busy, fifo_read_enb} !== 3'b000) begin
      errors++; $display("[TB] FAIL post_reset_idle got %b want 000", {m_valid, busy, fifo_read_enb});
    end
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic [11:0] expRd, expVal, expSop, expEop, expDone, expBusy;
    logic [7:0]  expData [0:11];
    expRd = 12'h03D; expVal = 12'h0F4; expSop = 12'h004; expEop = 12'h080;
    expDone = 12'h080; expBusy = 12'h0FE;
    for (int i = 0; i < 12; i++) expData[i] = 8'h00;
    expData[2] = 8'h0D; expData[4] = 8'h11; expData[5] = 8'h22; expData[6] = 8'h33; expData[7] = 8'h0D;
    m_ready = 1'b1;
    pushByte(8'h0D); pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h0D);
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if (fifo_read_enb !== expRd[c]) begin errors++; $display("[TB] FAIL basic_rd c%0d got %b want %b", c, fifo_read_enb, expRd[c]); end
      checks++;
      if (m_valid !== expVal[c]) begin errors++; $display("[TB] FAIL basic_valid c%0d got %b want %b", c, m_valid, expVal[c]); end
      checks++;
      if (busy !== expBusy[c]) begin errors++; $display("[TB] FAIL basic_busy c%0d got %b want %b", c, busy, expBusy[c]); end
      checks++;
      if ({pkt_done, parity_err} !== {expDone[c], 1'b0}) begin
        errors++; $display("[TB] FAIL basic_done c%0d got %b want %b", c, {pkt_done, parity_err}, {expDone[c], 1'b0});
      end
      if (expVal[c]) begin
        checks++;
        if ({m_sop, m_eop, m_data} !== {expSop[c], expEop[c], expData[c]}) begin
          errors++; $display("[TB] FAIL basic_byte c%0d got %b_%b_%h want %b_%b_%h",
                             c, m_sop, m_eop, m_data, expSop[c], expEop[c], expData[c]);
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_parity_error();
    logic [11:0] expDone;
    expDone = 12'h080;
    m_ready = 1'b1;
    pushByte(8'h0D); pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h0E);
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++;
      if ({pkt_done, parity_err} !== {expDone[c], expDone[c]}) begin
        errors++; $display("[TB] FAIL perr_pulse c%0d got %b want %b", c, {pkt_done, parity_err}, {expDone[c], expDone[c]});
      end
      if (c == 7) begin
        checks++;
        if ({m_eop, m_data} !== {1'b1, 8'h0E}) begin
          errors++; $display("[TB] FAIL perr_eop_byte got %b_%h want 1_0e", m_eop, m_data);
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pkt [0:64];
    logic [7:0] acc;
    logic [9:0] want;
    bit fin;
    pkt[0] = 8'hFE;
    acc = 8'hFE;
    for (int i = 1; i <= 63; i++) begin
      pkt[i] = 8'(i * 7 + 3);
      acc = acc ^ pkt[i];
    end
    pkt[64] = acc;
    clearRx();
    for (int i = 0; i < 65; i++) pushByte(pkt[i]);
    runStream(600, 1'b1, fin);
    m_ready = 1'b1;
    checks++;
    if (!fin) begin errors++; $display("[TB] FAIL bp_done_seen got 0 want 1"); end
    checks++;
    if (rxQ.size() != 65) begin errors++; $display("[TB] FAIL bp_count got %0d want 65", rxQ.size()); end
    for (int i = 0; i < 65 && i < rxQ.size(); i++) begin
      want = {(i == 0), (i == 64), pkt[i]};
      checks++;
      if (rxQ[i] !== want) begin errors++; $display("[TB] FAIL bp_byte%0d got %h want %h", i, rxQ[i], want); end
    end
    checks++;
    if ({rdViol, validViol} != {32'd0, 32'd0}) begin
      errors++; $display("[TB] FAIL bp_flow rdViol %0d validViol %0d want 0 0", rdViol, validViol);
    end
    checks++;
    if (maxOcc > 2) begin errors++; $display("[TB] FAIL bp_occ got %0d want <=2", maxOcc); end
    checks++;
    if ({doneCnt, errCnt, strayDone} != {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("[TB] FAIL bp_status done %0d err %0d stray %0d want 1 0 0", doneCnt, errCnt, strayDone);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_timeout();
    int hdrCyc, toCyc, toCnt;
    bit fin;
    logic [9:0] want [0:3];
    want[0] = {2'b10, 8'h0A}; want[1] = {2'b00, 8'h5A}; want[2] = {2'b00, 8'hA5}; want[3] = {2'b01, 8'hF5};
    clearRx();
    hdrCyc = -1; toCyc = -1; toCnt = 0;
    m_ready = 1'b0;
    pushByte(8'h0A); pushByte(8'h5A); pushByte(8'hA5); pushByte(8'hF5);
    for (int c = 0; c < 50; c++) begin
      #1;
      if (hdrCyc < 0 && m_valid) hdrCyc = c;
      if (timeout) begin toCnt++; toCyc = c; end
      tbOcc      = tbOcc + tbInflight;
      tbInflight = int'(fifo_read_enb);
      if (c == 49) begin
        checks++;
        if ({m_valid, m_sop, m_data} !== {2'b11, 8'h0A}) begin
          errors++; $display("[TB] FAIL to_stalled_head got %b_%b_%h want 1_1_0a", m_valid, m_sop, m_data);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (hdrCyc != 2) begin errors++; $display("[TB] FAIL to_hdr_cycle got %0d want 2", hdrCyc); end
    checks++;
    if (toCnt != 1) begin errors++; $display("[TB] FAIL to_pulse_count got %0d want 1", toCnt); end
    checks++;
    if (toCyc != hdrCyc + 30) begin errors++; $display("[TB] FAIL to_pulse_cycle got %0d want %0d", toCyc, hdrCyc + 30); end
    m_ready = 1'b1;
    runStream(60, 1'b0, fin);
    checks++;
    if (!fin) begin errors++; $display("[TB] FAIL to_resume_done got 0 want 1"); end
    checks++;
    if (rxQ.size() != 4) begin errors++; $display("[TB] FAIL to_resume_count got %0d want 4", rxQ.size()); end
    for (int i = 0; i < 4 && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== want[i]) begin errors++; $display("[TB] FAIL to_byte%0d got %h want %h", i, rxQ[i], want[i]); end
    end
    checks++;
    if ({errCnt, strayDone, timeoutCnt} != {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("[TB] FAIL to_resume_status err %0d stray %0d timeouts %0d want 0 0 0", errCnt, strayDone, timeoutCnt);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_len_zero();
    bit fin;
    clearRx();
    m_ready = 1'b1;
    pushByte(8'h00); pushByte(8'h00);
    runStream(30, 1'b0, fin);
    checks++;
    if (!fin) begin errors++; $display("[TB] FAIL len0_done got 0 want 1"); end
    checks++;
    if (rxQ.size() != 2) begin errors++; $display("[TB] FAIL len0_count got %0d want 2", rxQ.size()); end
    if (rxQ.size() == 2) begin
      checks++;
      if (rxQ[0] !== {2'b10, 8'h00}) begin errors++; $display("[TB] FAIL len0_hdr got %h want 200", rxQ[0]); end
      checks++;
      if (rxQ[1] !== {2'b01, 8'h00}) begin errors++; $display("[TB] FAIL len0_par got %h want 100", rxQ[1]); end
    end
    checks++;
    if ({doneCnt, errCnt, strayDone} != {32'd1, 32'd0, 32'd0}) begin
      errors++; $display("[TB] FAIL len0_status done %0d err %0d stray %0d want 1 0 0", doneCnt, errCnt, strayDone);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_soft_reset();
    int spurious;
    bit fin;
    logic [9:0] want [0:3];
    want[0] = {2'b10, 8'h09}; want[1] = {2'b00, 8'h44}; want[2] = {2'b00, 8'h88}; want[3] = {2'b01, 8'hC5};
    m_ready = 1'b1;
    pushByte(8'h0D); pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h0D);
    repeat (4) @(negedge clock);
    soft_reset = 1'b1;
    #1;
    checks++;
    if ({busy, pkt_done, fifo_read_enb} !== 3'b100) begin
      errors++; $display("[TB] FAIL srst_during got %b want 100", {busy, pkt_done, fifo_read_enb});
    end
    @(negedge clock);
    soft_reset = 1'b0;
    #1;
    checks++;
    if ({m_valid, busy, fifo_read_enb, pkt_done} !== 4'b0000) begin
      errors++; $display("[TB] FAIL srst_after got %b want 0000", {m_valid, busy, fifo_read_enb, pkt_done});
    end
    spurious = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      #1;
      if (pkt_done || m_valid || busy) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("[TB] FAIL srst_quiet got %0d active cycles want 0", spurious); end
    @(negedge clock);
    clearRx();
    pushByte(8'h09); pushByte(8'h44); pushByte(8'h88); pushByte(8'hC5);
    runStream(40, 1'b0, fin);
    checks++;
    if (!fin) begin errors++; $display("[TB] FAIL srst_next_done got 0 want 1"); end
    checks++;
    if (rxQ.size() != 4) begin errors++; $display("[TB] FAIL srst_next_count got %0d want 4", rxQ.size()); end
    for (int i = 0; i < 4 && i < rxQ.size(); i++) begin
      checks++;
      if (rxQ[i] !== want[i]) begin errors++; $display("[TB] FAIL srst_byte%0d got %h want %h", i, rxQ[i], want[i]); end
    end
    checks++;
    if ({errCnt, strayDone} != {32'd0, 32'd0}) begin
      errors++; $display("[TB] FAIL srst_next_status err %0d stray %0d want 0 0", errCnt, strayDone);
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; m_ready = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_parity_error();
    test_backpressure();
    test_timeout();
    test_len_zero();
    test_soft_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
